// File: rtl/unified_cache_bank_request_arbiter.sv
// unified_cache_bank_request_arbiter
// Front-end arbiter for one unified cache bank. Merges NUM_INPUT_PORT request
// ports and the miss-replay channel into a single registered packet stream.
// Priority tiers, highest first:
//   T0 urgent replay, T1 critical ports, T2 non-urgent replay, T3 normal ports.
// Ports inside T1/T3 are served round-robin starting at the rr pointer.
// Ports are acked combinationally in the same cycle the output register
// captures their packet, so a new packet can be loaded every cycle.
// Optional build macro UNIFIED_CACHE_ARB_AGING_EN adds per-port wait counters
// that promote a long-waiting normal port into T1.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif

module unified_cache_bank_request_arbiter #(
    parameter int NUM_INPUT_PORT  = 4,
    parameter int PACKET_WIDTH    = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int SOURCE_ID_WIDTH = $clog2(NUM_INPUT_PORT + 1),
    parameter int AGING_THRESHOLD = 15
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,
    input  logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0] request_flatted_in,
    input  logic [NUM_INPUT_PORT-1:0]              request_valid_flatted_in,
    input  logic [NUM_INPUT_PORT-1:0]              request_critical_flatted_in,
    output logic [NUM_INPUT_PORT-1:0]              issue_ack_out,
    input  logic [PACKET_WIDTH-1:0]                replay_request_in,
    input  logic                                   replay_request_valid_in,
    input  logic                                   replay_urgent_in,
    output logic                                   replay_ack_out,
    output logic [PACKET_WIDTH-1:0]                request_out,
    output logic                                   request_valid_out,
    output logic                                   request_critical_out,
    output logic [SOURCE_ID_WIDTH-1:0]             request_source_out,
    input  logic                                   issue_ack_in
);

    localparam int PTR_W = (NUM_INPUT_PORT > 1) ? $clog2(NUM_INPUT_PORT) : 1;

    // Output register and round-robin pointer
    logic [PACKET_WIDTH-1:0]    request_q, request_d;
    logic                       valid_q, valid_d;
    logic                       critical_q, critical_d;
    logic [SOURCE_ID_WIDTH-1:0] source_q, source_d;
    logic [PTR_W-1:0]           rr_q, rr_d;

    // Arbitration signals
    logic                       capture_en;
    logic                       fire;
    logic [NUM_INPUT_PORT-1:0]  promoted;
    logic [NUM_INPUT_PORT-1:0]  crit_mask;
    logic [NUM_INPUT_PORT-1:0]  norm_mask;
    logic [NUM_INPUT_PORT-1:0]  port_mask;
    logic                       grant_replay;
    logic                       grant_port;
    logic                       port_found;
    logic [PTR_W:0]             scan_sum;
    logic [PTR_W-1:0]           win_idx;
    logic [NUM_INPUT_PORT-1:0]  win_onehot;
    logic [PTR_W:0]             rr_inc;
    logic [PACKET_WIDTH-1:0]    win_packet;
    logic                       win_critical;

    // Tier selection: pick the port mask of the highest non-empty port tier and
    // decide whether the replay channel outranks it.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        capture_en   = !valid_q || issue_ack_in;
        fire         = capture_en && !reset_in;
        crit_mask    = request_valid_flatted_in & (request_critical_flatted_in | promoted);
        norm_mask    = request_valid_flatted_in & ~crit_mask;
        port_mask    = (|crit_mask) ? crit_mask : norm_mask;
        grant_replay = replay_request_valid_in &&
                       (replay_urgent_in || !(|crit_mask));
        grant_port   = !grant_replay && (|port_mask);
    end

    // Round-robin scan of the selected port mask, starting at the pointer and
    // wrapping from NUM_INPUT_PORT-1 back to 0.
    always_comb begin
        port_found = 1'b0;
        scan_sum   = '0;
        win_idx    = '0;
        for (int k = 0; k < NUM_INPUT_PORT; k++) begin
            scan_sum = {1'b0, rr_q} + (PTR_W + 1)'(k);
            if (scan_sum >= (PTR_W + 1)'(NUM_INPUT_PORT)) begin
                scan_sum = scan_sum - (PTR_W + 1)'(NUM_INPUT_PORT);
            end
            if (!port_found && port_mask[scan_sum[PTR_W-1:0]]) begin
                port_found = 1'b1;
                win_idx    = scan_sum[PTR_W-1:0];
            end
        end
    end

    // Winner decode: one-hot vector, packet and critical flag of the port winner.
    always_comb begin
        win_onehot   = '0;
        win_packet   = '0;
        for (int k = 0; k < NUM_INPUT_PORT; k++) begin
            win_onehot[k] = port_found && (win_idx == PTR_W'(k));
            if (win_onehot[k]) begin
                win_packet = request_flatted_in[k*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
        win_critical = |(win_onehot & request_critical_flatted_in);
        rr_inc       = {1'b0, win_idx} + (PTR_W + 1)'(1);
    end

    // Capture acks: one-hot, same cycle as the output register load, silent in reset.
    always_comb begin
        issue_ack_out  = (fire && grant_port) ? win_onehot : '0;
        replay_ack_out = fire && grant_replay;
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        request_d  = request_q;
        valid_d    = valid_q;
        critical_d = critical_q;
        source_d   = source_q;
        rr_d       = rr_q;
        if (capture_en) begin
            valid_d = grant_replay || grant_port;
            if (grant_replay) begin
                request_d  = replay_request_in;
                critical_d = replay_urgent_in;
                source_d   = SOURCE_ID_WIDTH'(NUM_INPUT_PORT);
            end else if (grant_port) begin
                request_d  = win_packet;
                critical_d = win_critical;
                source_d   = SOURCE_ID_WIDTH'(win_idx);
                rr_d       = (rr_inc >= (PTR_W + 1)'(NUM_INPUT_PORT)) ? '0 : rr_inc[PTR_W-1:0];
            end
        end
    end

    // Output register and pointer update with synchronous reset.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset_in) begin
            request_q  <= '0;
            valid_q    <= 1'b0;
            critical_q <= 1'b0;
            source_q   <= '0;
            rr_q       <= '0;
        end else begin
            request_q  <= request_d;
            valid_q    <= valid_d;
            critical_q <= critical_d;
            source_q   <= source_d;
            rr_q       <= rr_d;
        end
    end

`ifdef UNIFIED_CACHE_ARB_AGING_EN
    localparam int AGE_W = $clog2(AGING_THRESHOLD + 1);

    logic [NUM_INPUT_PORT-1:0][AGE_W-1:0] age_q, age_d;

    // Saturating wait counters: count while valid and not acked, clear otherwise.
    always_comb begin
        age_d    = age_q;
        promoted = '0;
        for (int k = 0; k < NUM_INPUT_PORT; k++) begin
            promoted[k] = (age_q[k] >= AGE_W'(AGING_THRESHOLD));
            if (!request_valid_flatted_in[k] || issue_ack_out[k]) begin
                age_d[k] = '0;
            end else if (age_q[k] < AGE_W'(AGING_THRESHOLD)) begin
                age_d[k] = age_q[k] + AGE_W'(1);
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Strict tiers: no port is ever promoted.
    logic unused_aging_threshold;
    assign unused_aging_threshold = (AGING_THRESHOLD != 0);
    assign promoted = '0;
`endif

    assign request_out          = request_q;
    assign request_valid_out    = valid_q;
    assign request_critical_out = critical_q;
    assign request_source_out   = source_q;

endmodule

// File: tb/tb_unified_cache_bank_request_arbiter.sv
// Directed self-checking bench for unified_cache_bank_request_arbiter (N=4).
// Inputs change 1 time unit after the rising edge; acks are sampled 1 unit later,
// registered outputs are sampled 1 unit after the following rising edge.

module tb_unified_cache_bank_request_arbiter;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int SW = 3;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic [N*PW-1:0]   request_flatted_in;
    logic [N-1:0]      request_valid_flatted_in;
    logic [N-1:0]      request_critical_flatted_in;
    logic [N-1:0]      issue_ack_out;
    logic [PW-1:0]     replay_request_in;
    logic              replay_request_valid_in;
    logic              replay_urgent_in;
    logic              replay_ack_out;
    logic [PW-1:0]     request_out;
    logic              request_valid_out;
    logic              request_critical_out;
    logic [SW-1:0]     request_source_out;
    logic              issue_ack_in;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [PW-1:0] REPLAY_PKT = 32'hBEEF_0004;

    unified_cache_bank_request_arbiter #(
        .NUM_INPUT_PORT (N),
        .PACKET_WIDTH   (PW),
        .AGING_THRESHOLD(15)
    ) dut (
        .clk_in                     (clk_in),
        .reset_in                   (reset_in),
        .request_flatted_in         (request_flatted_in),
        .request_valid_flatted_in   (request_valid_flatted_in),
        .request_critical_flatted_in(request_critical_flatted_in),
        .issue_ack_out              (issue_ack_out),
        .replay_request_in          (replay_request_in),
        .replay_request_valid_in    (replay_request_valid_in),
        .replay_urgent_in           (replay_urgent_in),
        .replay_ack_out             (replay_ack_out),
        .request_out                (request_out),
        .request_valid_out          (request_valid_out),
        .request_critical_out       (request_critical_out),
        .request_source_out         (request_source_out),
        .issue_ack_in               (issue_ack_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [PW-1:0] pkt(input int port);
        return 32'hA000_0000 + PW'(port);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        request_valid_flatted_in    = '0;
        request_critical_flatted_in = '0;
        replay_request_valid_in     = 1'b0;
        replay_urgent_in            = 1'b0;
        issue_ack_in                = 1'b0;
    endtask

    task automatic test_reset();
        reset_in                    = 1'b1;
        request_valid_flatted_in    = '1;
        request_critical_flatted_in = '1;
        replay_request_valid_in     = 1'b1;
        replay_urgent_in            = 1'b1;
        issue_ack_in                = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if ({issue_ack_out, replay_ack_out} !== 5'b0)
                $display("FAIL reset_acks[%0d]: got %b expected 00000", c, {issue_ack_out, replay_ack_out});
            else pass_cnt++;
            total_cnt++;
            if (request_valid_out !== 1'b0)
                $display("FAIL reset_valid[%0d]: got %b expected 0", c, request_valid_out);
            else pass_cnt++;
        end
        total_cnt++;
        if ({request_out, request_critical_out, request_source_out} !== '0)
            $display("FAIL reset_regs: got out=%h crit=%b src=%0d expected all 0",
                     request_out, request_critical_out, request_source_out);
        else pass_cnt++;
        reset_in = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        int exp_src [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_ack;
        request_valid_flatted_in = 4'b1111;
        issue_ack_in             = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            exp_ack = N'(1) << exp_src[k];
            total_cnt++;
            if (issue_ack_out !== exp_ack || replay_ack_out !== 1'b0)
                $display("FAIL rr_ack[%0d]: got %b/%b expected %b/0", k, issue_ack_out, replay_ack_out, exp_ack);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (request_valid_out !== 1'b1 || request_source_out !== SW'(exp_src[k]) ||
                request_out !== pkt(exp_src[k]))
                $display("FAIL rr_out[%0d]: got v=%b src=%0d pkt=%h expected v=1 src=%0d pkt=%h",
                         k, request_valid_out, request_source_out, request_out, exp_src[k], pkt(exp_src[k]));
            else pass_cnt++;
        end
        request_valid_flatted_in = '0;
        tick();
        total_cnt++;
        if (request_valid_out !== 1'b0)
            $display("FAIL rr_drain: got valid %b expected 0", request_valid_out);
        else pass_cnt++;
    endtask

    task automatic test_tiers();
        logic [N-1:0] exp_ack  [3] = '{4'b0100, 4'b0000, 4'b0001};
        logic         exp_rack [3] = '{1'b0, 1'b1, 1'b0};
        int           exp_src  [3] = '{2, 4, 0};
        logic         exp_crit [3] = '{1'b1, 1'b0, 1'b0};
        request_valid_flatted_in    = 4'b0101;
        request_critical_flatted_in = 4'b0100;
        replay_request_valid_in     = 1'b1;
        replay_urgent_in            = 1'b0;
        issue_ack_in                = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            total_cnt++;
            if (issue_ack_out !== exp_ack[k] || replay_ack_out !== exp_rack[k])
                $display("FAIL tier_ack[%0d]: got %b/%b expected %b/%b",
                         k, issue_ack_out, replay_ack_out, exp_ack[k], exp_rack[k]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (request_valid_out !== 1'b1 || request_source_out !== SW'(exp_src[k]) ||
                request_critical_out !== exp_crit[k])
                $display("FAIL tier_out[%0d]: got v=%b src=%0d crit=%b expected v=1 src=%0d crit=%b",
                         k, request_valid_out, request_source_out, request_critical_out, exp_src[k], exp_crit[k]);
            else pass_cnt++;
            if (k == 0) request_valid_flatted_in[2] = 1'b0;
            if (k == 1) replay_request_valid_in = 1'b0;
            if (k == 2) request_valid_flatted_in[0] = 1'b0;
        end
        request_critical_flatted_in = '0;
        tick();
        total_cnt++;
        if (request_valid_out !== 1'b0)
            $display("FAIL tier_drain: got valid %b expected 0", request_valid_out);
        else pass_cnt++;
    endtask

    task automatic test_urgent_replay();
        request_valid_flatted_in    = 4'b1111;
        request_critical_flatted_in = 4'b1111;
        replay_request_valid_in     = 1'b1;
        replay_urgent_in            = 1'b1;
        issue_ack_in                = 1'b1;
        settle();
        total_cnt++;
        if (issue_ack_out !== 4'b0000 || replay_ack_out !== 1'b1)
            $display("FAIL urgent_ack: got %b/%b expected 0000/1", issue_ack_out, replay_ack_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (request_source_out !== SW'(4) || request_critical_out !== 1'b1 || request_out !== REPLAY_PKT)
            $display("FAIL urgent_out: got src=%0d crit=%b pkt=%h expected src=4 crit=1 pkt=%h",
                     request_source_out, request_critical_out, request_out, REPLAY_PKT);
        else pass_cnt++;
        replay_request_valid_in = 1'b0;
        replay_urgent_in        = 1'b0;
        settle();
        total_cnt++;
        if (issue_ack_out !== 4'b0010 || replay_ack_out !== 1'b0)
            $display("FAIL urgent_next_ack: got %b/%b expected 0010/0", issue_ack_out, replay_ack_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (request_source_out !== SW'(1) || request_critical_out !== 1'b1 || request_out !== pkt(1))
            $display("FAIL urgent_next_out: got src=%0d crit=%b pkt=%h expected src=1 crit=1 pkt=%h",
                     request_source_out, request_critical_out, request_out, pkt(1));
        else pass_cnt++;
        idle_inputs();
        issue_ack_in = 1'b1;
        tick();
        total_cnt++;
        if (request_valid_out !== 1'b0)
            $display("FAIL urgent_drain: got valid %b expected 0", request_valid_out);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        issue_ack_in             = 1'b0;
        request_valid_flatted_in = 4'b1001;
        settle();
        total_cnt++;
        if (issue_ack_out !== 4'b1000)
            $display("FAIL stall_first_ack: got %b expected 1000", issue_ack_out);
        else pass_cnt++;
        tick();
        request_valid_flatted_in[3] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            total_cnt++;
            if (issue_ack_out !== 4'b0000 || replay_ack_out !== 1'b0)
                $display("FAIL stall_ack[%0d]: got %b/%b expected 0000/0", c, issue_ack_out, replay_ack_out);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (request_valid_out !== 1'b1 || request_source_out !== SW'(3) || request_out !== pkt(3))
                $display("FAIL stall_hold[%0d]: got v=%b src=%0d pkt=%h expected v=1 src=3 pkt=%h",
                         c, request_valid_out, request_source_out, request_out, pkt(3));
            else pass_cnt++;
        end
        issue_ack_in = 1'b1;
        settle();
        total_cnt++;
        if (issue_ack_out !== 4'b0001)
            $display("FAIL stall_release_ack: got %b expected 0001", issue_ack_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (request_valid_out !== 1'b1 || request_source_out !== SW'(0) || request_out !== pkt(0))
            $display("FAIL stall_no_bubble: got v=%b src=%0d pkt=%h expected v=1 src=0 pkt=%h",
                     request_valid_out, request_source_out, request_out, pkt(0));
        else pass_cnt++;
        request_valid_flatted_in = '0;
        tick();
        total_cnt++;
        if (request_valid_out !== 1'b0)
            $display("FAIL stall_drain: got valid %b expected 0", request_valid_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_transfer();
        issue_ack_in             = 1'b0;
        request_valid_flatted_in = 4'b0010;
        settle();
        total_cnt++;
        if (issue_ack_out !== 4'b0010)
            $display("FAIL midrst_load_ack: got %b expected 0010", issue_ack_out);
        else pass_cnt++;
        tick();
        request_valid_flatted_in = 4'b0100;
        issue_ack_in             = 1'b1;
        reset_in                 = 1'b1;
        settle();
        total_cnt++;
        if (issue_ack_out !== 4'b0000 || replay_ack_out !== 1'b0)
            $display("FAIL midrst_ack: got %b/%b expected 0000/0", issue_ack_out, replay_ack_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (request_valid_out !== 1'b0 || request_out !== '0 || request_source_out !== '0)
            $display("FAIL midrst_regs: got v=%b pkt=%h src=%0d expected v=0 pkt=0 src=0",
                     request_valid_out, request_out, request_source_out);
        else pass_cnt++;
        reset_in = 1'b0;
        settle();
        total_cnt++;
        if (issue_ack_out !== 4'b0100)
            $display("FAIL midrst_represent_ack: got %b expected 0100", issue_ack_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (request_valid_out !== 1'b1 || request_source_out !== SW'(2) || request_out !== pkt(2))
            $display("FAIL midrst_represent_out: got v=%b src=%0d pkt=%h expected v=1 src=2 pkt=%h",
                     request_valid_out, request_source_out, request_out, pkt(2));
        else pass_cnt++;
        request_valid_flatted_in = '0;
        tick();
    endtask

    task automatic test_aging();
        int   grant_cycle = -1;
        logic [SW-1:0] got_src  = '0;
        logic          got_crit = 1'b1;
        request_valid_flatted_in    = 4'b1001;
        request_critical_flatted_in = 4'b0001;
        issue_ack_in                = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (grant_cycle < 0) begin
                settle();
                if (issue_ack_out[3] === 1'b1) grant_cycle = c;
                tick();
                if (grant_cycle == c) begin
                    got_src  = request_source_out;
                    got_crit = request_critical_out;
                    request_valid_flatted_in[3] = 1'b0;
                end
            end
        end
`ifdef UNIFIED_CACHE_ARB_AGING_EN
        total_cnt++;
        if (grant_cycle < 15 || grant_cycle > 17)
            $display("FAIL aging_grant_cycle: got %0d expected 15..17", grant_cycle);
        else pass_cnt++;
        total_cnt++;
        if (got_src !== SW'(3) || got_crit !== 1'b0)
            $display("FAIL aging_out: got src=%0d crit=%b expected src=3 crit=0", got_src, got_crit);
        else pass_cnt++;
`else
        total_cnt++;
        if (grant_cycle != -1)
            $display("FAIL starve_grant_cycle: got %0d expected never granted (-1)", grant_cycle);
        else pass_cnt++;
        total_cnt++;
        if (request_source_out !== SW'(0) || request_critical_out !== 1'b1)
            $display("FAIL starve_out: got src=%0d crit=%b expected src=0 crit=1",
                     request_source_out, request_critical_out);
        else pass_cnt++;
`endif
        idle_inputs();
        tick();
    endtask

    initial begin
        reset_in = 1'b1;
        for (int i = 0; i < N; i++) request_flatted_in[i*PW +: PW] = pkt(i);
        replay_request_in = REPLAY_PKT;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_tiers();
        test_urgent_replay();
        test_back_pressure();
        test_reset_mid_transfer();
        test_aging();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
